keypad_scan_in: RTL and testbench

- Input-side counterpart of the multiplexed 7-segment display driver: scans a 4x4 active-low hex matrix keypad one column at a time.
- Debounces each key and reports one clean event per press.
- Shifts the entered hex digits into a 32-bit value, which the display path can show directly.
- Sits in the PDU next to the display driver, on the same board clock.

---
 rtl/keypad_scan_in_pkg.sv | 50 +++++
 rtl/keypad_scan_in_scan_tick.sv | 44 ++++
 rtl/keypad_scan_in.sv | 167 ++++++++++++++++
 tb/tb_keypad_scan_in.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scan_in_pkg.sv
// ============================================================================
// Module : keypad_scan_in_pkg
// Brief  : Shared encodings and helpers for the matrix keypad scanner.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package keypad_scan_in_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DEB  = 2'd1,
        S_HELD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } scan_res_t;

    typedef struct packed {
        scan_res_t  res;
        logic [3:0] key;
    } scan_t;

    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam int         DIGIT_W   = 4;
    localparam int         DIGIT_N   = 8;
    localparam int         VALUE_W   = DIGIT_W * DIGIT_N;

    // Key code is {row, column}, i.e. 4*r + c.
    function automatic scan_t sample_decode(input logic [3:0] row_n, input logic [1:0] c);
        scan_t s;
        s.res = RES_NONE;
        s.key = 4'd0;
        case (~row_n)
            4'b0000: s.res = RES_NONE;
            4'b0001: begin s.res = RES_SINGLE; s.key = {2'd0, c}; end
            4'b0010: begin s.res = RES_SINGLE; s.key = {2'd1, c}; end
            4'b0100: begin s.res = RES_SINGLE; s.key = {2'd2, c}; end
            4'b1000: begin s.res = RES_SINGLE; s.key = {2'd3, c}; end
            default: s.res = RES_MULTI;
        endcase
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scan_in_scan_tick.sv
// ============================================================================
// Module : scan_tick
// Brief  : Slot counter for scanned I/O; flags the last clock of each slot
//          and of the final slot of a full scan.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module scan_tick #(
    parameter int SCAN_DIV = 200000,
    parameter int SLOTS    = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    output logic                     slot_end,
    output logic                     scan_end,
    output logic [$clog2(SLOTS)-1:0] slot
);

    localparam int                CNT_W     = $clog2(SCAN_DIV);
    localparam int                SLOT_W    = $clog2(SLOTS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt  <= '0;
            slot <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            slot <= (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign slot_end = (cnt == CNT_LAST);
    assign scan_end = slot_end && (slot == SLOT_LAST);

endmodule

`default_nettype wire

// File: rtl/keypad_scan_in.sv
// ============================================================================
// Module : keypad_scan_in
// Brief  : 4x4 active-low keypad scanner with debounce and 8-digit hex entry.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module keypad_scan_in
    import keypad_scan_in_pkg::*;
#(
    parameter int SCAN_DIV  = 200000,
    parameter int DEB_SCANS = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [3:0]         row,
    input  logic               clr,
    output logic [3:0]         col,
    output logic [3:0]         key_code,
    output logic               key_valid,
    output logic               pressed,
    output logic [VALUE_W-1:0] value
);

    localparam int               CNT_W    = $clog2(DEB_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_SCANS);

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic             slot_end;
    logic             scan_end;
    logic [1:0]       slot;
    scan_t            sample;
    scan_t            acc;
    scan_t            merged;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cand;

    scan_tick #(
        .SCAN_DIV (SCAN_DIV),
        .SLOTS    (4)
    ) u_scan_tick (
        .clk      (clk),
        .rstn     (rstn),
        .slot_end (slot_end),
        .scan_end (scan_end),
        .slot     (slot)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col <= COL_RESET;
        end else if (slot_end) begin
            col <= {col[2:0], col[3]};
        end
    end

    assign sample = sample_decode(row_sync, slot);

    // Keys in two different columns make the scan ambiguous, same as a multi sample.
    always_comb begin
        merged = acc;
        case (acc.res)
            RES_NONE:   merged = sample;
            RES_SINGLE: if (sample.res != RES_NONE) merged.res = RES_MULTI;
            default:    merged.res = RES_MULTI;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc.res <= RES_NONE;
            acc.key <= 4'd0;
        end else if (scan_end) begin
            acc.res <= RES_NONE;
            acc.key <= 4'd0;
        end else if (slot_end) begin
            acc <= merged;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cand      <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            pressed   <= 1'b0;
            value     <= '0;
        end else begin
            key_valid <= 1'b0;
            if (clr) value <= '0;
            if (scan_end) begin
                case (state)
                    S_IDLE: begin
                        if (merged.res == RES_SINGLE) begin
                            cand    <= merged.key;
                            pressed <= 1'b1;
                            if (DEB_SCANS == 1) begin
                                state     <= S_HELD;
                                cnt       <= '0;
                                key_valid <= 1'b1;
                                key_code  <= merged.key;
                                if (!clr) value <= {value[VALUE_W-DIGIT_W-1:0], merged.key};
                            end else begin
                                state <= S_DEB;
                                cnt   <= CNT_ONE;
                            end
                        end
                    end
                    S_DEB: begin
                        if (merged.res == RES_SINGLE && merged.key == cand) begin
                            if (cnt + CNT_ONE == DEB_LAST) begin
                                state     <= S_HELD;
                                cnt       <= '0;
                                key_valid <= 1'b1;
                                key_code  <= cand;
                                if (!clr) value <= {value[VALUE_W-DIGIT_W-1:0], cand};
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end else begin
                            state   <= S_IDLE;
                            cnt     <= '0;
                            pressed <= 1'b0;
                        end
                    end
                    S_HELD: begin
                        // Only consecutive empty scans count towards release.
                        if (merged.res == RES_NONE) begin
                            if (cnt + CNT_ONE == DEB_LAST) begin
                                state   <= S_IDLE;
                                cnt     <= '0;
                                pressed <= 1'b0;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        pressed <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan_in.sv
// ============================================================================
// Module : tb_keypad_scan_in
// Brief  : Scoreboard bench for keypad_scan_in with a per-scan reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_keypad_scan_in;

    localparam int SCAN_DIV  = 8;
    localparam int DEB_SCANS = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        pressed;
    logic [31:0] value;
    logic [15:0] mask = 16'h0000;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [35:0] exp_q[$];

    int          m_state = 0;
    int          m_cnt = 0;
    logic [3:0]  m_cand = 4'd0;
    logic [31:0] m_value = 32'd0;

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column's drive.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) row[r] = ~|(mask[4*r +: 4] & ~col);
    end

    keypad_scan_in #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_SCANS (DEB_SCANS)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .row       (row),
        .clr       (clr),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .pressed   (pressed),
        .value     (value)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] key_mask(input int k);
        logic [15:0] one;
        one = 16'h0001;
        return one << k;
    endfunction

    // One full scan of a static key set: 0 keys, 1 key, or an ambiguous set.
    task automatic model_scan(input logic [15:0] m, input bit do_clr);
        int  n;
        int  k;
        bit  accept;
        n = $countones(m);
        k = 0;
        for (int i = 0; i < 16; i++) if (m[i]) k = i;
        accept = 1'b0;
        case (m_state)
            0: if (n == 1) begin
                m_cand = 4'(k);
                m_cnt  = 1;
                if (m_cnt >= DEB_SCANS) begin accept = 1'b1; m_state = 2; m_cnt = 0; end
                else m_state = 1;
            end
            1: if (n == 1 && 4'(k) == m_cand) begin
                m_cnt++;
                if (m_cnt >= DEB_SCANS) begin accept = 1'b1; m_state = 2; m_cnt = 0; end
            end else begin
                m_state = 0;
                m_cnt   = 0;
            end
            default: if (n == 0) begin
                m_cnt++;
                if (m_cnt >= DEB_SCANS) begin m_state = 0; m_cnt = 0; end
            end else begin
                m_cnt = 0;
            end
        endcase
        if (accept) begin
            m_value = do_clr ? 32'd0 : {m_value[27:0], m_cand};
            exp_q.push_back({m_cand, m_value});
        end else if (do_clr) begin
            m_value = 32'd0;
        end
    endtask

    // Starts on the negedge right after a scan-end edge and ends on the next one.
    task automatic run_scan(input logic [15:0] m, input bit do_clr);
        model_scan(m, do_clr);
        mask = m;
        repeat (4 * SCAN_DIV - 1) @(negedge clk);
        clr = do_clr;
        @(negedge clk);
        clr = 1'b0;
        check("pressed", {31'd0, pressed}, {31'd0, m_state != 0});
    endtask

    task automatic press(input int k, input int hold, input int rel);
        repeat (hold) run_scan(key_mask(k), 1'b0);
        repeat (rel) run_scan(16'h0000, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rstn && key_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_key_valid", {31'd0, key_valid}, 32'd0);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                check("key_code", {28'd0, key_code}, {28'd0, e[35:32]});
                check("value_at_pulse", value, e[31:0]);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx;
        logic [3:0] exp_col;
        repeat (3) @(negedge clk);
        check("rst_col", {28'd0, col}, 32'h0000000E);
        check("rst_value", value, 32'd0);
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_key_code", {28'd0, key_code}, 32'd0);
        check("rst_pressed", {31'd0, pressed}, 32'd0);
        rstn = 1'b1;
        for (int k = 1; k <= 4 * SCAN_DIV; k++) begin
            @(negedge clk);
            if (k % 4 == 0 || k % SCAN_DIV == SCAN_DIV - 1) begin
                idx     = (k / SCAN_DIV) % 4;
                exp_col = ~(4'b0001 << idx);
                check("col_rotation", {28'd0, col}, {28'd0, exp_col});
            end
        end

        // Digit entry: 5, A, 3
        press(5, 5, 3);
        press(10, 3, 3);
        press(3, 3, 3);
        check("value_5A3", value, 32'h000005A3);

        // Bounce on key 7
        press(7, 2, 1);
        press(7, 2, 3);
        check("value_after_bounce", value, 32'h000005A3);

        // Multiple keys
        repeat (6) run_scan(16'h0003, 1'b0);
        repeat (3) run_scan(16'h0044, 1'b0);
        repeat (3) run_scan(16'h0000, 1'b0);
        check("value_after_multi", value, 32'h000005A3);

        // Hold without repeat, short release, re-press
        press(15, 20, 2);
        press(15, 1, 3);
        press(15, 3, 3);
        check("value_after_hold", value, 32'h005A3FF);

        // Overflow past 8 digits
        for (int d = 1; d <= 9; d++) press(d, 3, 3);
        check("value_overflow", value, 32'h23456789);

        // clr together with an accept
        run_scan(key_mask(4), 1'b0);
        run_scan(key_mask(4), 1'b0);
        run_scan(key_mask(4), 1'b1);
        check("value_clr_wins", value, 32'd0);
        repeat (3) run_scan(16'h0000, 1'b0);

        // Reset in the middle of debounce
        press(2, 3, 3);
        run_scan(key_mask(9), 1'b0);
        run_scan(key_mask(9), 1'b0);
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("mid_rst_col", {28'd0, col}, 32'h0000000E);
        check("mid_rst_value", value, 32'd0);
        check("mid_rst_key_code", {28'd0, key_code}, 32'd0);
        check("mid_rst_pressed", {31'd0, pressed}, 32'd0);
        repeat (3) @(negedge clk);
        mask    = 16'h0000;
        m_state = 0;
        m_cnt   = 0;
        m_value = 32'd0;
        rstn    = 1'b1;
        repeat (4) run_scan(16'h0000, 1'b0);
        check("value_after_mid_rst", value, 32'd0);

        // Randomized episodes
        for (int ep = 0; ep < 40; ep++) begin
            int a;
            int b;
            int hold;
            int rel;
            logic [15:0] m;
            a    = int'($urandom_range(0, 15));
            hold = int'($urandom_range(1, 5));
            rel  = int'($urandom_range(1, 4));
            m    = key_mask(a);
            if ($urandom_range(0, 9) == 0) begin
                b = (a + 1 + int'($urandom_range(0, 14))) % 16;
                m = m | key_mask(b);
            end
            repeat (hold) run_scan(m, $urandom_range(0, 7) == 0);
            repeat (rel) run_scan(16'h0000, $urandom_range(0, 7) == 0);
        end
        repeat (4) run_scan(16'h0000, 1'b0);
        check("final_value", value, m_value);
        check("pending_events", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
